// File: rtl/xosera_rst_boot_seq_pkg.sv
// Shared types and board-default timing for the Xosera reset/warmboot sequencer.
package xosera_rst_boot_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STRETCH,
    RUN,
    BOOT_ARM,
    BOOT
  } rst_seq_state_t;

  localparam int RST_LOCK_FILTER = 4;
  localparam int RST_HOLD        = 8;
  localparam int RST_BOOT_DELAY  = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xosera_rst_boot_seq_lock_filter.sv
// Qualifies the AND of all PLL lock flags: strobes once after LOCK_FILTER consecutive locked cycles.
module xosera_rst_boot_seq_lock_filter
  import xosera_rst_boot_seq_pkg::*;
#(
  parameter int NUM_LOCKS   = 1,
  parameter int LOCK_FILTER = RST_LOCK_FILTER
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic                 clear_i,
  input  logic [NUM_LOCKS-1:0] pll_lock_i,
  output logic                 qualified_o,
  output logic                 locked_o
);

  localparam int FILT_W = cnt_w(LOCK_FILTER);

  if (NUM_LOCKS < 1)   begin : g_bad_num_locks   $error("NUM_LOCKS must be >= 1");   end
  if (LOCK_FILTER < 1) begin : g_bad_lock_filter $error("LOCK_FILTER must be >= 1"); end

  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;

  assign locked_o    = &pll_lock_i;
  assign qualified_o = locked_o && !clear_i && (filt_cnt_q == FILT_W'(LOCK_FILTER - 1));

  // Counter restarts on any unlocked sample and after each qualification.
  always_comb begin
    filt_cnt_d = filt_cnt_q + FILT_W'(1);
    if (clear_i || !locked_o || qualified_o) begin
      filt_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_d;
    end
  end

endmodule

// File: rtl/xosera_rst_boot_seq.sv
// Board reset/warmboot sequencer: lock qualification, reset stretch, lock-loss accounting, warmboot arming.
module xosera_rst_boot_seq
  import xosera_rst_boot_seq_pkg::*;
#(
  parameter int NUM_LOCKS   = 1,
  parameter int LOCK_FILTER = RST_LOCK_FILTER,
  parameter int RESET_HOLD  = RST_HOLD,
  parameter int BOOT_DELAY  = RST_BOOT_DELAY,
  parameter int LOSS_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic [NUM_LOCKS-1:0]  pll_lock_i,
  input  logic                  reconfig_i,
  input  logic [1:0]            boot_select_i,
  output logic                  reset_o,
  output logic                  ready_o,
  output logic                  warmboot_o,
  output logic [1:0]            warmboot_sel_o,
  output logic                  lock_lost_o,
  output logic [LOSS_CNT_W-1:0] lock_lost_cnt_o
);

  localparam int HOLD_W = cnt_w(RESET_HOLD);
  localparam int BOOT_W = cnt_w(BOOT_DELAY);

  if (RESET_HOLD < 1) begin : g_bad_reset_hold $error("RESET_HOLD must be >= 1"); end
  if (BOOT_DELAY < 1) begin : g_bad_boot_delay $error("BOOT_DELAY must be >= 1"); end

  rst_seq_state_t         state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [BOOT_W-1:0]      boot_cnt_q, boot_cnt_d;
  logic                   reset_q, reset_d;
  logic                   ready_q, ready_d;
  logic                   warmboot_q, warmboot_d;
  logic [1:0]             sel_q, sel_d;
  logic                   lost_q, lost_d;
  logic [LOSS_CNT_W-1:0]  lost_cnt_q, lost_cnt_d;
  logic                   all_locked;
  logic                   lock_qualified;

  xosera_rst_boot_seq_lock_filter #(
    .NUM_LOCKS  (NUM_LOCKS),
    .LOCK_FILTER(LOCK_FILTER)
  ) u_lock_filter (
    .clk        (clk),
    .reset_i    (reset_i),
    .clear_i    (state_q != WAIT_LOCK),
    .pll_lock_i (pll_lock_i),
    .qualified_o(lock_qualified),
    .locked_o   (all_locked)
  );

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q    <= WAIT_LOCK;
      hold_cnt_q <= '0;
      boot_cnt_q <= '0;
      reset_q    <= 1'b1;
      ready_q    <= 1'b0;
      warmboot_q <= 1'b0;
      sel_q      <= '0;
      lost_q     <= 1'b0;
      lost_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      boot_cnt_q <= boot_cnt_d;
      reset_q    <= reset_d;
      ready_q    <= ready_d;
      warmboot_q <= warmboot_d;
      sel_q      <= sel_d;
      lost_q     <= lost_d;
      lost_cnt_q <= lost_cnt_d;
    end
  end

  // Lock loss outranks a reconfig request in RUN; once armed, the boot proceeds regardless of locks.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_LOCK: if (lock_qualified) state_d = STRETCH;
      STRETCH: begin
        if (!all_locked)                                    state_d = WAIT_LOCK;
        else if (hold_cnt_q == HOLD_W'(RESET_HOLD - 1))     state_d = RUN;
      end
      RUN: begin
        if (!all_locked)      state_d = WAIT_LOCK;
        else if (reconfig_i)  state_d = BOOT_ARM;
      end
      BOOT_ARM: if (boot_cnt_q == BOOT_W'(BOOT_DELAY - 1)) state_d = BOOT;
      BOOT:     state_d = BOOT;
      default:  state_d = WAIT_LOCK;
    endcase

    hold_cnt_d = '0;
    if (state_q == STRETCH && state_d == STRETCH) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    boot_cnt_d = '0;
    if (state_q == BOOT_ARM && state_d == BOOT_ARM) boot_cnt_d = boot_cnt_q + BOOT_W'(1);
  end

  always_comb begin
    reset_d    = (state_d != RUN);
    ready_d    = (state_d == RUN);
    warmboot_d = (state_d == BOOT);
    sel_d      = sel_q;
    if (state_q == RUN && state_d == BOOT_ARM) sel_d = boot_select_i;
    lost_d     = (state_q == RUN) && (state_d == WAIT_LOCK);
    lost_cnt_d = lost_cnt_q;
    if (lost_d && (lost_cnt_q != '1)) lost_cnt_d = lost_cnt_q + LOSS_CNT_W'(1);
  end

  assign reset_o         = reset_q;
  assign ready_o         = ready_q;
  assign warmboot_o      = warmboot_q;
  assign warmboot_sel_o  = sel_q;
  assign lock_lost_o     = lost_q;
  assign lock_lost_cnt_o = lost_cnt_q;

endmodule

// File: tb/tb_xosera_rst_boot_seq.sv
// Bench for xosera_rst_boot_seq: directed scenarios plus random traffic against a lock-streak model.
module tb_xosera_rst_boot_seq;

  localparam int NL  = 2;
  localparam int LF  = 4;
  localparam int RH  = 8;
  localparam int BD  = 16;
  localparam int LCW = 2;

  logic           clk = 1'b0;
  logic           reset_i = 1'b1;
  logic [NL-1:0]  pll_lock_i = '0;
  logic           reconfig_i = 1'b0;
  logic [1:0]     boot_select_i = '0;
  logic           reset_o, ready_o, warmboot_o, lock_lost_o;
  logic [1:0]     warmboot_sel_o;
  logic [LCW-1:0] lock_lost_cnt_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: the block runs once it has seen LF+RH consecutive locked samples outside RUN/boot.
  int       m_streak = 0;
  int       m_arm_left = 0;
  bit       m_run = 0, m_armed = 0, m_boot = 0, m_lost = 0;
  logic [1:0] m_sel = '0;
  int       m_cnt = 0;

  xosera_rst_boot_seq #(
    .NUM_LOCKS  (NL),
    .LOCK_FILTER(LF),
    .RESET_HOLD (RH),
    .BOOT_DELAY (BD),
    .LOSS_CNT_W (LCW)
  ) dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .pll_lock_i     (pll_lock_i),
    .reconfig_i     (reconfig_i),
    .boot_select_i  (boot_select_i),
    .reset_o        (reset_o),
    .ready_o        (ready_o),
    .warmboot_o     (warmboot_o),
    .warmboot_sel_o (warmboot_sel_o),
    .lock_lost_o    (lock_lost_o),
    .lock_lost_cnt_o(lock_lost_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [8:0] dut_vec();
    return {reset_o, ready_o, warmboot_o, warmboot_sel_o, lock_lost_o, lock_lost_cnt_o};
  endfunction

  function automatic logic [8:0] model_vec();
    return {~m_run, m_run, m_boot, m_sel, m_lost, 2'(m_cnt)};
  endfunction

  task automatic model_edge();
    bit locked = &pll_lock_i;
    m_lost = 0;
    if (reset_i) begin
      m_streak = 0; m_arm_left = 0; m_run = 0; m_armed = 0; m_boot = 0; m_sel = '0; m_cnt = 0;
    end else if (m_boot) begin
      m_boot = 1;
    end else if (m_armed) begin
      m_arm_left--;
      if (m_arm_left == 0) begin m_armed = 0; m_boot = 1; end
    end else if (m_run) begin
      if (!locked) begin
        m_run = 0; m_streak = 0; m_lost = 1;
        if (m_cnt < (1 << LCW) - 1) m_cnt++;
      end else if (reconfig_i) begin
        m_run = 0; m_armed = 1; m_arm_left = BD; m_sel = boot_select_i;
      end
    end else begin
      m_streak = locked ? m_streak + 1 : 0;
      if (m_streak == LF + RH) begin m_run = 1; m_streak = 0; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Applies reset with both locks high, returns edges counted from release until ready_o.
  task automatic reset_to_run(output int n);
    reset_i = 1'b1; pll_lock_i = '1; reconfig_i = 1'b0;
    tick(); tick();
    reset_i = 1'b0;
    n = 0;
    while (!ready_o && n < 100) begin tick(); n++; end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; pll_lock_i = 2'b11; reconfig_i = 1'b1; boot_select_i = 2'b11;
    tick(); tick();
    tests_run++;
    if (dut_vec() !== 9'b1_0_0_00_0_00) begin
      tests_failed++;
      $display("FAIL reset_values: got %b expected %b", dut_vec(), 9'b1_0_0_00_0_00);
    end
    reconfig_i = 1'b0;
  endtask

  task automatic test_power_up();
    int n;
    reset_to_run(n);
    tests_run++;
    if (n !== LF + RH || ready_o !== 1'b1 || reset_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL power_up_latency: got %0d edges ready=%b reset=%b expected %0d edges ready=1 reset=0",
               n, ready_o, reset_o, LF + RH);
    end
  endtask

  task automatic test_glitch();
    int n;
    reset_i = 1'b1; pll_lock_i = 2'b11;
    tick(); tick();
    reset_i = 1'b0;
    tick(); tick();
    pll_lock_i = 2'b01;
    tick();
    pll_lock_i = 2'b11;
    n = 0;
    while (reset_o && n < 100) begin tick(); n++; end
    tests_run++;
    if (n !== LF + RH) begin
      tests_failed++;
      $display("FAIL glitch_restart: got %0d edges expected %0d", n, LF + RH);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    int exp_cnt;
    reset_to_run(n);
    for (int i = 1; i <= 4; i++) begin
      exp_cnt = (i > 3) ? 3 : i;
      pll_lock_i = 2'b10;
      tick();
      tests_run++;
      if ({reset_o, ready_o, lock_lost_o, lock_lost_cnt_o} !== {3'b101, 2'(exp_cnt)}) begin
        tests_failed++;
        $display("FAIL lock_loss_%0d: got rst/rdy/lost/cnt %b%b%b/%0d expected 101/%0d",
                 i, reset_o, ready_o, lock_lost_o, lock_lost_cnt_o, exp_cnt);
      end
      pll_lock_i = 2'b11;
      tick();
      n = 1;
      tests_run++;
      if (lock_lost_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL lock_lost_pulse_width_%0d: got %b expected 0", i, lock_lost_o);
      end
      while (!ready_o && n < 100) begin tick(); n++; end
      tests_run++;
      if (n !== LF + RH) begin
        tests_failed++;
        $display("FAIL relock_latency_%0d: got %0d expected %0d", i, n, LF + RH);
      end
    end
  endtask

  task automatic test_reconfig();
    int n;
    reset_to_run(n);
    reconfig_i = 1'b1; boot_select_i = 2'b10;
    tick();
    tests_run++;
    if ({reset_o, ready_o, warmboot_o, warmboot_sel_o} !== 5'b1_0_0_10) begin
      tests_failed++;
      $display("FAIL boot_arm_entry: got %b expected %b",
               {reset_o, ready_o, warmboot_o, warmboot_sel_o}, 5'b1_0_0_10);
    end
    reconfig_i = 1'b0; boot_select_i = 2'b01;
    for (int k = 1; k < BD; k++) begin
      tick();
      tests_run++;
      if ({reset_o, warmboot_o, warmboot_sel_o} !== 4'b1_0_10) begin
        tests_failed++;
        $display("FAIL boot_arm_hold_%0d: got %b expected %b", k,
                 {reset_o, warmboot_o, warmboot_sel_o}, 4'b1_0_10);
      end
    end
    tick();
    tests_run++;
    if ({reset_o, ready_o, warmboot_o, warmboot_sel_o} !== 5'b1_0_1_10) begin
      tests_failed++;
      $display("FAIL boot_entry: got %b expected %b",
               {reset_o, ready_o, warmboot_o, warmboot_sel_o}, 5'b1_0_1_10);
    end
    repeat (5) tick();
    tests_run++;
    if ({warmboot_o, warmboot_sel_o} !== 3'b1_10) begin
      tests_failed++;
      $display("FAIL boot_sticky: got %b expected %b", {warmboot_o, warmboot_sel_o}, 3'b1_10);
    end
  endtask

  task automatic test_reconfig_vs_loss();
    int n;
    int seen_wb;
    reset_to_run(n);
    reconfig_i = 1'b1; boot_select_i = 2'b11; pll_lock_i = 2'b10;
    tick();
    tests_run++;
    if ({reset_o, lock_lost_o, lock_lost_cnt_o} !== 4'b1_1_01) begin
      tests_failed++;
      $display("FAIL reconfig_vs_loss: got %b expected %b",
               {reset_o, lock_lost_o, lock_lost_cnt_o}, 4'b1_1_01);
    end
    reconfig_i = 1'b0; pll_lock_i = 2'b11;
    seen_wb = 0;
    repeat (40) begin
      tick();
      if (warmboot_o !== 1'b0) seen_wb++;
    end
    tests_run++;
    if (seen_wb !== 0 || ready_o !== 1'b1 || warmboot_sel_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL no_boot_after_loss: got wb_cycles=%0d ready=%b sel=%b expected 0/1/00",
               seen_wb, ready_o, warmboot_sel_o);
    end
  endtask

  task automatic test_boot_arm_lock_reset();
    int n;
    reset_to_run(n);
    reconfig_i = 1'b1; boot_select_i = 2'b11;
    tick();
    reconfig_i = 1'b0; pll_lock_i = 2'b00;
    repeat (5) tick();
    tests_run++;
    if ({reset_o, lock_lost_o, lock_lost_cnt_o, warmboot_o} !== 5'b1_0_00_0) begin
      tests_failed++;
      $display("FAIL arm_ignores_loss: got %b expected %b",
               {reset_o, lock_lost_o, lock_lost_cnt_o, warmboot_o}, 5'b1_0_00_0);
    end
    pll_lock_i = 2'b11;
    repeat (BD - 6) tick();
    tests_run++;
    if (warmboot_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL arm_early_boot: got %b expected 0", warmboot_o);
    end
    tick();
    tests_run++;
    if ({warmboot_o, warmboot_sel_o} !== 3'b1_11) begin
      tests_failed++;
      $display("FAIL arm_lock_boot: got %b expected %b", {warmboot_o, warmboot_sel_o}, 3'b1_11);
    end
    repeat (3) tick();
    reset_i = 1'b1;
    tick();
    tests_run++;
    if (dut_vec() !== 9'b1_0_0_00_0_00) begin
      tests_failed++;
      $display("FAIL reset_from_boot: got %b expected %b", dut_vec(), 9'b1_0_0_00_0_00);
    end
    reset_i = 1'b0;
  endtask

  task automatic test_random();
    logic [NL-1:0] lk;
    reset_i = 1'b1;
    tick();
    for (int c = 0; c < 3000; c++) begin
      reset_i = ($urandom_range(0, 199) == 0);
      lk = '1;
      for (int b = 0; b < NL; b++) if ($urandom_range(0, 39) == 0) lk[b] = 1'b0;
      pll_lock_i    = lk;
      reconfig_i    = ($urandom_range(0, 99) == 0);
      boot_select_i = 2'($urandom);
      tick();
      tests_run++;
      if (dut_vec() !== model_vec()) begin
        tests_failed++;
        $display("FAIL random_cycle_%0d: got %b expected %b", c, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_power_up();
    test_glitch();
    test_lock_loss();
    test_reconfig();
    test_reconfig_vs_loss();
    test_boot_arm_lock_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
